// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine (C = A x B) with
// skewed operand feed, start/done control and row-wise result drain; SYSTOLIC_ZERO_SKIP_EN adds skip_cnt.
module systolic_mm_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int K_W    = 8,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_vec,
  input  logic [COLS*DATA_W-1:0]  b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_row,
  output logic [RW-1:0]           out_row_idx,
  output logic                    done
`ifdef SYSTOLIC_ZERO_SKIP_EN
  , output logic [15:0]           skip_cnt
`endif
);
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;

  logic [K_W-1:0] k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic           done_q, done_d;
  logic           start_acc, feed_hs, drain_hs, last_beat, flush_end, last_row;

  assign start_acc = (state_q == IDLE) && start;
  assign feed_hs   = in_valid && in_ready;
  assign drain_hs  = out_valid && out_ready;
  assign last_beat = (k_cnt_q == k_len_q - K_W'(1));
  assign flush_end = (flush_cnt_q == FW'(FLUSH_LEN - 1));
  assign last_row  = (row_q == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_len == '0) ? DRAIN : FEED;
      FEED:    if (feed_hs && last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DRAIN;
      DRAIN:   if (drain_hs && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == FEED);
    out_valid = (state_q == DRAIN);
  end

  always_comb begin
    k_len_d     = start_acc ? k_len : k_len_q;
    k_cnt_d     = start_acc ? '0 : (feed_hs ? k_cnt_q + K_W'(1) : k_cnt_q);
    flush_cnt_d = (state_q == FLUSH) ? flush_cnt_q + FW'(1) : '0;
    row_d       = start_acc ? '0 : (drain_hs ? (last_row ? '0 : row_q + RW'(1)) : row_q);
    done_d      = drain_hs && last_row;
  end
  assign done        = done_q;
  assign out_row_idx = row_q;

  logic signed [DATA_W-1:0] a_row [ROWS];
  logic                     v_row [ROWS];
  logic signed [DATA_W-1:0] b_col [COLS];
  logic signed [DATA_W-1:0] a_pe  [ROWS][COLS];
  logic                     v_pe  [ROWS][COLS];
  logic signed [DATA_W-1:0] b_pe  [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc_pe[ROWS][COLS];
`ifdef SYSTOLIC_ZERO_SKIP_EN
  logic [ROWS*COLS-1:0]     skip_hit;
`endif

  genvar gi, gj;
  // Row i carries {valid, a} through i stages so beats arrive diagonally aligned.
  for (gi = 0; gi < ROWS; gi++) begin : g_row_skew
    logic [DATA_W:0] src;
    assign src = feed_hs ? {1'b1, a_vec[gi*DATA_W +: DATA_W]} : '0;
    if (gi == 0) begin : g_direct
      assign {v_row[gi], a_row[gi]} = src;
    end else begin : g_chain
      logic [DATA_W:0] sk_q [gi];
      logic [DATA_W:0] sk_d [gi];
      always_comb begin
        sk_d[0] = src;
        for (int s = 1; s < gi; s++) sk_d[s] = sk_q[s-1];
      end
      always_ff @(posedge clk) begin
        if (rst) for (int s = 0; s < gi; s++) sk_q[s] <= '0;
        else     sk_q <= sk_d;
      end
      assign {v_row[gi], a_row[gi]} = sk_q[gi-1];
    end
  end

  for (gj = 0; gj < COLS; gj++) begin : g_col_skew
    logic [DATA_W-1:0] src;
    assign src = feed_hs ? b_vec[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_direct
      assign b_col[gj] = src;
    end else begin : g_chain
      logic [DATA_W-1:0] sk_q [gj];
      logic [DATA_W-1:0] sk_d [gj];
      always_comb begin
        sk_d[0] = src;
        for (int s = 1; s < gj; s++) sk_d[s] = sk_q[s-1];
      end
      always_ff @(posedge clk) begin
        if (rst) for (int s = 0; s < gj; s++) sk_q[s] <= '0;
        else     sk_q <= sk_d;
      end
      assign b_col[gj] = sk_q[gj-1];
    end
  end

  for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
    for (gj = 0; gj < COLS; gj++) begin : g_pe_col
      logic signed [DATA_W-1:0]   a_in, b_in, a_q, a_d, b_q, b_d;
      logic                       v_in, v_q, v_d, wr_en;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    acc_q, acc_d;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_row[gi];
        assign v_in = v_row[gi];
      end else begin : g_a_mid
        assign a_in = a_pe[gi][gj-1];
        assign v_in = v_pe[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = b_col[gj];
      end else begin : g_b_mid
        assign b_in = b_pe[gi-1][gj];
      end

      assign prod = a_in * b_in;
`ifdef SYSTOLIC_ZERO_SKIP_EN
      // A zero operand contributes nothing, so the write is dropped and counted instead.
      assign wr_en = v_in && (a_in != '0) && (b_in != '0);
      assign skip_hit[gi*COLS + gj] = v_in && ((a_in == '0) || (b_in == '0));
`else
      assign wr_en = v_in;
`endif

      always_comb begin
        a_d   = a_in;
        b_d   = b_in;
        v_d   = v_in;
        acc_d = start_acc ? '0 : (wr_en ? acc_q + ACC_W'(prod) : acc_q);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          v_q   <= 1'b0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          v_q   <= v_d;
          acc_q <= acc_d;
        end
      end

      assign a_pe[gi][gj]   = a_q;
      assign b_pe[gi][gj]   = b_q;
      assign v_pe[gi][gj]   = v_q;
      assign acc_pe[gi][gj] = acc_q;
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == DRAIN)
      for (int j = 0; j < COLS; j++) out_row[j*ACC_W +: ACC_W] = acc_pe[row_q][j];
  end

`ifdef SYSTOLIC_ZERO_SKIP_EN
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [31:0] skip_sum;
  always_comb begin
    skip_sum   = {16'b0, skip_cnt_q} + 32'($countones(skip_hit));
    skip_cnt_d = start_acc ? '0 : ((skip_sum > 32'hFFFF) ? 16'hFFFF : skip_sum[15:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) skip_cnt_q <= '0;
    else     skip_cnt_q <= skip_cnt_d;
  end
  assign skip_cnt = skip_cnt_q;
`endif
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: table of uniform-operand jobs plus hand-written
// identity, stall, backpressure, reset and (with SYSTOLIC_ZERO_SKIP_EN) zero-skip sequences.
module tb_systolic_mm_engine;
  localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 24, K_W = 8;

  logic                   clk = 1'b0;
  logic                   rst, start, in_valid, out_ready;
  logic [K_W-1:0]         k_len;
  logic                   busy, in_ready, out_valid, done;
  logic [ROWS*DATA_W-1:0] a_vec;
  logic [COLS*DATA_W-1:0] b_vec;
  logic [COLS*ACC_W-1:0]  out_row;
  logic [1:0]             out_row_idx;
`ifdef SYSTOLIC_ZERO_SKIP_EN
  logic [15:0]            skip_cnt;
`endif

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .done(done)
`ifdef SYSTOLIC_ZERO_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int a;
    int b;
    int exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic signed [DATA_W-1:0] abeat [256][ROWS];
  logic signed [DATA_W-1:0] bbeat [256][COLS];
  int exp_c [ROWS][COLS];
  bit vpat [8];
  int vpat_len = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int k, input int a, input int b, input int e);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) abeat[kk][i] = DATA_W'(a);
      for (int j = 0; j < COLS; j++) bbeat[kk][j] = DATA_W'(b);
    end
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++) exp_c[r][j] = e;
  endtask

  task automatic ref_model(input int k);
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++) begin
        int sum = 0;
        for (int kk = 0; kk < k; kk++) sum += int'(abeat[kk][r]) * int'(bbeat[kk][j]);
        exp_c[r][j] = sum;
      end
  endtask

  task automatic check_row(input int r, input string tag);
    logic [ACC_W-1:0] e;
    for (int j = 0; j < COLS; j++) begin
      e = exp_c[r][j][ACC_W-1:0];
      check($sformatf("%s row%0d col%0d", tag, r, j), 64'(out_row[j*ACC_W +: ACC_W]), 64'(e));
    end
    check($sformatf("%s row_idx%0d", tag, r), 64'(out_row_idx), 64'(r));
    check($sformatf("%s out_valid%0d", tag, r), 64'(out_valid), 64'd1);
  endtask

  task automatic run_job(input string tag, input int k, input int hold_row, input int hold_n,
                         input bit chk_lat, input bit busy_start);
    int   edges = 0;
    int   bi = 0;
    int   p = 0;
    int   guard = 0;
    logic rdy;
    k_len = K_W'(k);
    start = 1'b1;
    step();
    edges++;
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    while (bi < k && guard < 2000) begin
      rdy      = in_ready;
      in_valid = (vpat_len == 0) ? 1'b1 : vpat[p % vpat_len];
      p++;
      for (int i = 0; i < ROWS; i++) a_vec[i*DATA_W +: DATA_W] = abeat[bi][i];
      for (int j = 0; j < COLS; j++) b_vec[j*DATA_W +: DATA_W] = bbeat[bi][j];
      if (busy_start && bi == 1) begin
        start = 1'b1;
        k_len = K_W'(9);
      end
      @(posedge clk);
      if (in_valid && rdy) bi++;
      #1;
      start = 1'b0;
      edges++;
      guard++;
    end
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    check({tag, " beats_accepted"}, 64'(bi), 64'(k));
    if (k > 0) check({tag, " in_ready_after_last"}, 64'(in_ready), 64'd0);
    guard = 0;
    while (!out_valid && guard < 300) begin
      step();
      edges++;
      guard++;
    end
    check({tag, " out_valid_seen"}, 64'(out_valid), 64'd1);
    if (chk_lat) check({tag, " latency"}, 64'(edges), 64'(1 + k + ROWS + COLS - 1));
    for (int r = 0; r < ROWS; r++) begin
      if (r == hold_row) begin
        for (int h = 0; h < hold_n; h++) begin
          out_ready = 1'b0;
          check_row(r, {tag, " held"});
          step();
        end
      end
      out_ready = 1'b1;
      check_row(r, tag);
      step();
    end
    check({tag, " done_pulse"}, 64'(done), 64'd1);
    check({tag, " busy_after_done"}, 64'(busy), 64'd0);
    $display("job %s k_len=%0d completed in %0d cycles to first row", tag, k, edges);
    step();
    check({tag, " done_clear"}, 64'(done), 64'd0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{k: 255, a: -128, b: -128, exp: 4177920};
    tbl[1] = '{k: 255, a: 127,  b: -128, exp: -4145280};
    tbl[2] = '{k: 0,   a: 5,    b: 5,    exp: 0};
    tbl[3] = '{k: 4,   a: 1,    b: 1,    exp: 4};
    tbl[4] = '{k: 7,   a: -3,   b: 5,    exp: -105};
    tbl[5] = '{k: 2,   a: -128, b: 127,  exp: -32512};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    k_len = '0; a_vec = '0; b_vec = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out_row", 64'(out_row), 64'd0);
    check("reset out_row_idx", 64'(out_row_idx), 64'd0);

    // Identity A times B returns the rows of B.
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < ROWS; i++) abeat[kk][i] = (i == kk) ? 8'sd1 : 8'sd0;
      for (int j = 0; j < COLS; j++) bbeat[kk][j] = DATA_W'(kk * 4 + j + 1);
    end
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++) exp_c[r][j] = r * 4 + j + 1;
    run_job("identity", 4, -1, 0, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_const(tbl[t].k, tbl[t].a, tbl[t].b, tbl[t].exp);
      run_job($sformatf("tbl%0d", t), tbl[t].k, -1, 0, tbl[t].k > 0, t == 3);
    end

    // Mixed-sign operands, unstalled, then with input bubbles, then with drain backpressure.
    for (int kk = 0; kk < 3; kk++) begin
      for (int i = 0; i < ROWS; i++) abeat[kk][i] = DATA_W'((i + 1) * (kk + 1) - 3);
      for (int j = 0; j < COLS; j++) bbeat[kk][j] = DATA_W'(2 * j - kk + 1);
    end
    ref_model(3);
    run_job("mixed", 3, -1, 0, 1'b1, 1'b0);
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
    vpat_len = 6;
    run_job("stalled", 3, -1, 0, 1'b0, 1'b0);
    vpat_len = 0;
    run_job("backpressure", 3, 2, 5, 1'b1, 1'b0);

    // Abort a job mid-FEED with reset, then run a clean job.
    fill_const(5, 7, 7, 0);
    k_len = K_W'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = {4{8'sd7}};
    b_vec = {4{8'sd7}};
    repeat (2) step();
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd0);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort out_row", 64'(out_row), 64'd0);
    rst = 1'b0;
    step();
    fill_const(1, 2, 3, 6);
    run_job("after_reset", 1, -1, 0, 1'b1, 1'b0);

`ifdef SYSTOLIC_ZERO_SKIP_EN
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < ROWS; i++) abeat[kk][i] = (kk == 0) ? 8'sd0 : DATA_W'(i + kk);
      for (int j = 0; j < COLS; j++) bbeat[kk][j] = DATA_W'(j + kk + 1);
    end
    ref_model(4);
    run_job("zero_skip", 4, -1, 0, 1'b1, 1'b0);
    check("zero_skip skip_cnt", 64'(skip_cnt), 64'd16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
Parametrised output-stationary ROWS x COLS systolic matrix-multiply engine computing C = A x B over a runtime inner dimension k_len.
- Built-in input skewing, a start/done control FSM, valid/ready streaming of operand beats, and row-by-row valid/ready drain of results.
- Successor to the fixed 4x4 free-running array; sits between the operand fetch unit and the result writeback path.

Parameters:
ROWS, 4, array rows (rows of A / C)
COLS, 4, array columns (columns of B / C)
DATA_W, 8, signed operand width
ACC_W, 24, signed accumulator width
K_W, 8, width of k_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin job; sampled only in IDLE
k_len  in  K_W  inner dimension, latched on start
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat
a_vec  in  ROWS*DATA_W  A[i][k] in slice i (row 0 at LSBs)
b_vec  in  COLS*DATA_W  B[k][j] in slice j
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row  out  COLS*ACC_W  C[r][j] in slice j
out_row_idx  out  $clog2(ROWS) (min 1)  row index r of out_row
done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset: FSM to IDLE; all accumulators, skew registers, pipes and counters to 0. busy, in_ready, out_valid, done, out_row and out_row_idx all 0. Reset applies identically mid-job; the partial job is discarded.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE, start=1:
  - Latch k_len.
  - Clear all accumulators.
  - Next state is FEED, or DRAIN if k_len==0 (outputs all-zero rows).
- FEED:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) is one k-step.
  - Row i operand is delayed i cycles by the skew chain; column j operand is delayed j cycles.
  - Cycles with no handshake inject zero operands with valid bit 0. This is a bubble and leaves the accumulators unchanged.
  - After the k_len-th handshake, go to FLUSH.
- FLUSH:
  - in_ready=0.
  - Lasts exactly ROWS+COLS-1 cycles (counter), enough for the last beat to reach PE(ROWS-1, COLS-1).
  - Then go to DRAIN.
- DRAIN:
  - out_valid=1, starting at row 0.
  - out_row and out_row_idx stay stable while out_valid & !out_ready.
  - Each handshake advances the row.
  - The handshake on row ROWS-1 sends the FSM to IDLE and asserts done for one cycle in that transition cycle (done is registered, visible the cycle after the handshake).
- PE arithmetic:
  - acc <= acc + sext(a*b); a*b is a 2*DATA_W signed product sign-extended to ACC_W.
  - Wraps modulo 2^ACC_W; no saturation.
  - Operands and the valid bit move one PE right/down per cycle.
- start while busy is ignored.
- A new start is accepted in the cycle after done (IDLE).
- Back-to-back: in_valid held high gives a FEED duration of exactly k_len cycles.
- Total latency from start to first out_valid, with no stalls: 1 + k_len + ROWS+COLS-1 cycles.

Optional Feature:
SYSTOLIC_ZERO_SKIP_EN
- Defined:
  - Each PE suppresses its accumulator write when a valid-tagged operand pair has a==0 or b==0 (sparse operand power saving).
  - Adds output port skip_cnt [15:0]: number of valid MACs skipped in the current job.
  - skip_cnt is cleared on accepted start, saturates at 16'hFFFF, holds after done, and is cleared by rst.
  - C results are identical to the non-skip build.
- Undefined: every valid MAC writes; no skip_cnt port.

Test Plan:
1. ROWS=COLS=4, k_len=4, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, out_ready=1 -> rows 0..3 equal the B rows; done 1 cycle after the row-3 handshake; first out_valid at cycle 1+4+7 after start.
2. k_len=255, all a=-128, all b=-128 -> every C = 4177920. Then all a=127, b=-128 -> every C = -4145280 (two's complement in 24 bits).
3. k_len=3 with in_valid toggling 1,0,0,1,0,1 -> results equal the unstalled run; in_ready drops after the third handshake.
4. DRAIN with out_ready low for 5 cycles on row 2 -> out_row/out_row_idx=2 held stable; no row lost or duplicated.
5. rst pulsed mid-FEED, then a new job k_len=1, a=all 2, b=all 3 -> all C = 6; no residue from the aborted job. Also: start while busy is ignored, and k_len=0 drains 4 zero rows.
6. SYSTOLIC_ZERO_SKIP_EN, k_len=4, A column 0 all zero, others nonzero -> skip_cnt = 16; C matches the reference product.
